// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg : shared types and width helpers for the fetch front end   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fetch_pkg;

  localparam int FETCH_W      = 16;
  localparam int FETCH_QDEPTH = 4;

  typedef enum logic [1:0] {
    FL_NONE  = 2'd0,
    FL_EXCPT = 2'd1,
    FL_RTI   = 2'd2,
    FL_REDIR = 2'd3
  } flush_cause_e;

  typedef struct packed {
    logic [FETCH_W-1:0] instr;
    logic [FETCH_W-1:0] pc;
  } fetch_entry_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int FETCH_PTR_W = ptr_w(FETCH_QDEPTH);
  localparam int FETCH_CNT_W = cnt_w(FETCH_QDEPTH);

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_if : instruction-memory and decode handshake bundle            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface fetch_if #(
  parameter int WIDTH = fetch_pkg::FETCH_W
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [WIDTH-1:0] imem_rdata;
  logic             instr_valid;
  logic             instr_ready;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] instr_pc;
  logic [WIDTH-1:0] instr_inc_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr_valid, instr, instr_pc, instr_inc_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr_valid, instr, instr_pc, instr_inc_pc,
    output instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_queue : synchronous prefetch FIFO with clear and occupancy     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  QDEPTH = FETCH_QDEPTH,
  parameter type T      = fetch_entry_t
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               i_push,
  input  wire T                   i_data,
  input  wire logic               i_pop,
  input  wire logic               i_clear,
  output T                        o_data,
  output logic                    o_empty,
  output logic [$clog2(QDEPTH):0] o_count
);
  localparam int PTR_W = ptr_w(QDEPTH);
  localparam int CNT_W = cnt_w(QDEPTH);

  T                 r_mem [QDEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(QDEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  // A full queue may still accept a push when the head leaves in the same cycle.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit : decoupled instruction fetch with PC/EPC and prefetch Q  |
// | Optional perf counters: define FETCH_PERF_CNT_EN                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int WIDTH     = FETCH_W,
  parameter int QDEPTH    = FETCH_QDEPTH,
  parameter int INC       = 2,
  parameter int RESET_VEC = 0,
  parameter int EXCPT_VEC = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  fetch_if.master               bus,
  input  wire logic             redirect,
  input  wire logic [WIDTH-1:0] redirect_pc,
  input  wire logic             exception,
  input  wire logic [WIDTH-1:0] excpt_ret_pc,
  input  wire logic             rti,
  input  wire logic             halt,
  output logic                  in_excpt
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_flushes
`endif
);
  localparam int               CNT_W       = cnt_w(QDEPTH);
  localparam logic [WIDTH-1:0] c_reset_vec = WIDTH'(RESET_VEC);
  localparam logic [WIDTH-1:0] c_excpt_vec = WIDTH'(EXCPT_VEC);
  localparam logic [WIDTH-1:0] c_inc       = WIDTH'(INC);
  localparam logic [CNT_W:0]   c_depth     = (CNT_W+1)'(QDEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc;
  } entry_t;

  logic [WIDTH-1:0] r_pc, r_epc, r_resp_pc;
  logic             r_in_excpt, r_halted;
  logic [CNT_W-1:0] r_outstanding, r_drop_cnt;

  flush_cause_e     w_cause;
  logic [WIDTH-1:0] w_flush_pc;
  logic             w_flush, w_room, w_grant, w_resp, w_drop, w_push, w_pop, w_q_empty;
  logic [CNT_W-1:0] w_q_count, w_outstanding_nxt;
  entry_t           w_push_data, w_head;

  always_comb begin
    w_cause    = FL_NONE;
    w_flush_pc = r_pc;
    if (exception) begin
      w_cause    = FL_EXCPT;
      w_flush_pc = c_excpt_vec;
    end else if (rti && r_in_excpt) begin
      w_cause    = FL_RTI;
      w_flush_pc = r_epc;
    end else if (redirect) begin
      w_cause    = FL_REDIR;
      w_flush_pc = redirect_pc;
    end
  end

  assign w_flush = (w_cause != FL_NONE);
  // Reserve a queue slot for every request in flight so responses never overflow.
  assign w_room  = ({1'b0, w_q_count} + {1'b0, r_outstanding}) < c_depth;

  assign bus.imem_req  = ~rst & ~r_halted & ~w_flush & w_room;
  assign bus.imem_addr = r_pc;

  assign w_grant = bus.imem_req & bus.imem_gnt;
  assign w_resp  = bus.imem_rvalid & (r_outstanding != '0);
  assign w_drop  = w_resp & (r_drop_cnt != '0);
  assign w_push  = w_resp & ~w_drop & ~w_flush;
  assign w_pop   = bus.instr_valid & bus.instr_ready;

  assign w_outstanding_nxt = r_outstanding + CNT_W'(w_grant) - CNT_W'(w_resp);
  assign w_push_data       = '{instr: bus.imem_rdata, pc: r_resp_pc};

  // r_resp_pc tracks the address of the next response that will be kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= c_reset_vec;
      r_resp_pc     <= c_reset_vec;
      r_epc         <= '0;
      r_in_excpt    <= 1'b0;
      r_halted      <= 1'b0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      if (halt) r_halted <= 1'b1;
      if (w_flush) begin
        r_pc       <= w_flush_pc;
        r_resp_pc  <= w_flush_pc;
        r_drop_cnt <= w_outstanding_nxt;
      end else begin
        if (w_grant) r_pc       <= r_pc + c_inc;
        if (w_push)  r_resp_pc  <= r_resp_pc + c_inc;
        if (w_drop)  r_drop_cnt <= r_drop_cnt - 1'b1;
      end
      case (w_cause)
        FL_EXCPT: begin
          r_in_excpt <= 1'b1;
          if (!r_in_excpt) r_epc <= excpt_ret_pc;
        end
        FL_RTI:  r_in_excpt <= 1'b0;
        default: r_in_excpt <= r_in_excpt;
      endcase
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH),
    .T      (entry_t)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_clear (w_flush),
    .o_data  (w_head),
    .o_empty (w_q_empty),
    .o_count (w_q_count)
  );

  assign bus.instr_valid  = ~rst & ~w_q_empty;
  assign bus.instr        = w_head.instr;
  assign bus.instr_pc     = w_head.pc;
  assign bus.instr_inc_pc = w_head.pc + c_inc;
  assign in_excpt         = r_in_excpt;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched, r_perf_flushes;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_flushes <= '0;
    end else begin
      if (w_pop && (r_perf_fetched != '1))   r_perf_fetched <= r_perf_fetched + 1'b1;
      if (w_flush && (r_perf_flushes != '1)) r_perf_flushes <= r_perf_flushes + 1'b1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_flushes = r_perf_flushes;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// tb_fetch_unit: table vectors, directed corner sequences and random traffic
// against an epoch-tagged program-order scoreboard with an in-order memory.
module tb_fetch_unit;
  localparam int W  = 16;
  localparam int QD = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         redirect, exception, rti, halt, in_excpt;
  logic [W-1:0] redirect_pc, excpt_ret_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]  perf_fetched, perf_flushes;
`endif

  always #5 clk = ~clk;

  fetch_if #(.WIDTH(W)) bus ();

  fetch_unit #(
    .WIDTH(W), .QDEPTH(QD), .INC(2), .RESET_VEC(0), .EXCPT_VEC(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .exception    (exception),
    .excpt_ret_pc (excpt_ret_pc),
    .rti          (rti),
    .halt         (halt),
    .in_excpt     (in_excpt)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushes (perf_flushes)
`endif
  );

  typedef struct {
    logic [W-1:0] addr;
    int           due;
    int           epoch;
  } req_t;

  typedef struct {
    bit           exc, rt, red;
    logic [W-1:0] rpc, ret, exp_pc;
    bit           exp_in;
  } vec_t;

  req_t         pend[$];
  int           cyc, total, bad;
  int           gnt_pct, ready_pct, lat_min, lat_max;
  logic [W-1:0] m_pc_req, m_pc_dec, m_epc;
  bit           m_in_excpt, m_halted;
  int           m_epoch, m_queued;
  bit           ob_req, ob_valid, ob_hs, ob_grant, ob_inexc;
  logic [W-1:0] ob_addr, ob_hs_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_pc_req   = '0;
    m_pc_dec   = '0;
    m_epc      = '0;
    m_in_excpt = 0;
    m_halted   = 0;
    m_queued   = 0;
    m_epoch    = 0;
  endtask

  // One clock: drive memory/ready, sample, score, advance.
  task automatic step();
    bit           fl;
    logic [W-1:0] tgt, e_pc, e_ins, e_inc;
    int           lat;
    bus.imem_gnt    = ($urandom_range(99) < gnt_pct);
    bus.instr_ready = ($urandom_range(99) < ready_pct);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = ~pend[0].addr;
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = W'($urandom);
    end
    #2;
    ob_req   = bus.imem_req;
    ob_addr  = bus.imem_addr;
    ob_valid = bus.instr_valid;
    ob_inexc = in_excpt;
    ob_hs    = bus.instr_valid & bus.instr_ready;
    ob_grant = bus.imem_req & bus.imem_gnt;
    ob_hs_pc = bus.instr_pc;
    if (rst) begin
      chk("rst_req", ob_req, 0);
      chk("rst_valid", ob_valid, 0);
      model_reset();
    end else begin
      fl  = 1'b1;
      tgt = '0;
      if (exception)               tgt = 16'h0002;
      else if (rti && m_in_excpt)  tgt = m_epc;
      else if (redirect)           tgt = redirect_pc;
      else                         fl  = 1'b0;
      chk("req", ob_req, (!m_halted && !fl && (m_queued + pend.size() < QD)) ? 1 : 0);
      if (ob_req) chk("addr", ob_addr, m_pc_req);
      chk("valid", ob_valid, (m_queued != 0) ? 1 : 0);
      chk("in_excpt", ob_inexc, m_in_excpt);
      if (ob_hs) begin
        e_pc  = m_pc_dec;
        e_ins = ~m_pc_dec;
        e_inc = m_pc_dec + 16'd2;
        chk("instr_pc", bus.instr_pc, e_pc);
        chk("instr", bus.instr, e_ins);
        chk("instr_inc_pc", bus.instr_inc_pc, e_inc);
        m_pc_dec = m_pc_dec + 16'd2;
        if (m_queued > 0) m_queued--;
      end
      if (bus.imem_rvalid) begin
        if (pend[0].epoch == m_epoch && !fl) m_queued++;
        void'(pend.pop_front());
      end
      if (ob_grant) begin
        lat = $urandom_range(lat_max, lat_min);
        pend.push_back('{addr: m_pc_req, due: cyc + lat, epoch: m_epoch});
        m_pc_req = m_pc_req + 16'd2;
      end
      if (fl) begin
        m_epoch++;
        m_queued = 0;
        m_pc_req = tgt;
        m_pc_dec = tgt;
        if (exception) begin
          if (!m_in_excpt) m_epc = excpt_ret_pc;
          m_in_excpt = 1;
        end else if (rti && m_in_excpt) begin
          m_in_excpt = 0;
        end
      end
      if (halt) m_halted = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_ctrl();
    redirect = 0; exception = 0; rti = 0; halt = 0;
  endtask

  task automatic do_reset();
    clear_ctrl();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_mem(input int g, input int r, input int lmin, input int lmax);
    gnt_pct = g; ready_pct = r; lat_min = lmin; lat_max = lmax;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t         tbl[8];
    logic [W-1:0] pcs[8];
    int           hcyc[8];
    int           n, grants, c0;
    bit           anyreq;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0042, 16'h0002, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0080, 16'h0002, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0042, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 16'h0200, 16'h0000, 16'h0200, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 16'h0300, 16'h0010, 16'h0002, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 16'h0400, 16'h0000, 16'h0400, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 16'h0500, 16'h0000, 16'h0010, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 16'hFFFE, 16'h0000, 16'hFFFE, 1'b0};

    total = 0; bad = 0; cyc = 0;
    redirect_pc = '0; excpt_ret_pc = '0;
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = '0; bus.instr_ready = 0;
    set_mem(100, 100, 1, 1);
    model_reset();
    @(posedge clk);
    #1;

    // Streaming at full rate
    do_reset();
    c0 = cyc; n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ob_hs && n < 8) begin pcs[n] = ob_hs_pc; hcyc[n] = cyc - 1; n++; end
    end
    chk("stream_count", (n >= 6) ? 1 : 0, 1);
    if (n >= 6) begin
      chk("stream_first_lat", hcyc[0] - c0, 2);
      for (int k = 0; k < 6; k++) begin
        chk("stream_pc", pcs[k], 16'(2 * k));
        chk("stream_back2back", hcyc[k] - hcyc[0], k);
      end
    end

    // Backpressure
    do_reset();
    set_mem(100, 0, 1, 1);
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ob_grant) grants++;
    end
    chk("bp_grants", grants, QD);
    chk("bp_req_low", ob_req, 0);
    ready_pct = 100;
    n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      step();
      if (ob_hs) begin pcs[n] = ob_hs_pc; n++; end
    end
    chk("bp_delivered", n, 4);
    for (int k = 0; k < n; k++) chk("bp_order", pcs[k], 16'(2 * k));

    // Redirect with two responses in flight
    do_reset();
    set_mem(100, 100, 3, 3);
    step();
    step();
    redirect = 1; redirect_pc = 16'h0100;
    step();
    chk("redir_req_low", ob_req, 0);
    redirect = 0;
    n = 0;
    for (int i = 0; i < 20 && n == 0; i++) begin
      step();
      if (ob_hs) begin pcs[0] = ob_hs_pc; n = 1; end
    end
    chk("redir_seen", n, 1);
    if (n == 1) chk("redir_first_pc", pcs[0], 16'h0100);

    // Control-priority table, one flush per vector
    do_reset();
    set_mem(0, 100, 1, 1);
    for (int i = 0; i < 8; i++) begin
      exception    = tbl[i].exc;
      rti          = tbl[i].rt;
      redirect     = tbl[i].red;
      redirect_pc  = tbl[i].rpc;
      excpt_ret_pc = tbl[i].ret;
      step();
      chk("tbl_flush_req", ob_req, 0);
      clear_ctrl();
      step();
      chk("tbl_pc", ob_addr, tbl[i].exp_pc);
      chk("tbl_in_excpt", ob_inexc, tbl[i].exp_in);
      chk("tbl_req", ob_req, 1);
    end

    // PC wrap from 0xFFFE
    gnt_pct = 100;
    step();
    chk("wrap_grant", ob_grant, 1);
    gnt_pct = 0;
    step();
    chk("wrap_pc", ob_addr, 16'h0000);
    for (int i = 0; i < 3; i++) step();

    // Halt with three entries queued
    do_reset();
    set_mem(100, 0, 1, 1);
    step();
    step();
    halt = 1;
    step();
    halt = 0;
    step();
    ready_pct = 100;
    n = 0; anyreq = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ob_hs) n++;
      if (ob_req) anyreq = 1;
    end
    chk("halt_delivered", n, 3);
    chk("halt_req", anyreq, 0);

    // Reset mid-stream
    do_reset();
    set_mem(100, 100, 1, 2);
    for (int i = 0; i < 10; i++) step();
    rst = 1;
    step();
    rst = 0;
    step();
    chk("rst_valid_after", ob_valid, 0);
    chk("rst_pc_after", ob_addr, 16'h0000);

    // Random traffic with sporadic control events
    do_reset();
    set_mem(70, 60, 1, 4);
    for (int i = 0; i < 3000; i++) begin
      redirect     = ($urandom_range(99) < 3);
      exception    = ($urandom_range(99) < 2);
      rti          = ($urandom_range(99) < 3);
      redirect_pc  = W'($urandom) & 16'hFFFE;
      excpt_ret_pc = W'($urandom) & 16'hFFFE;
      step();
    end
    clear_ctrl();
    for (int i = 0; i < 10; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
